// File: rtl/sram_controller.sv
// sram_controller: multi-cycle bridge between the MEM stage and a 16-bit off-chip SRAM.
// Each 32-bit access is split into a low half-word phase followed by a high half-word
// phase, each holding the bus for PHASE_CYCLES cycles. ready drops for the whole
// transaction so the pipeline freezes until the access completes.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   wr_en, rd_en      store / load request from MEM (write wins if both are high)
//   address           word-aligned byte address
//   write_data        store data
//   read_data         last loaded word (held across writes)
//   ready             no transaction outstanding, or one is completing
//   sram_addr         half-word address
//   sram_dq_out/oe    write data and its tri-state enable
//   sram_dq_in        read data from the SRAM
//   sram_*_n          active-low SRAM strobes
module sram_controller #(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter logic [31:0] DATA_BASE    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_wr_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  logic          req;
  logic          busy;
  logic          phase_end;
  logic [31:0]   offset;
  logic          unused_offset_bits;

  assign req       = wr_en | rd_en;
  assign busy      = (state_q == LOW) || (state_q == HIGH);
  assign phase_end = (cnt_q == LAST);

  // Subtraction wraps modulo 2^32; only the half-word index bits reach the bus.
  assign offset             = addr_q - DATA_BASE;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          cnt_d   = '0;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;  // DONE: requests here belong to the retiring instruction
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        op_wr_q <= wr_en;
        addr_q  <= address;
        wdata_q <= write_data;
      end
      // Sample the SRAM on the final cycle of each read phase.
      if (!op_wr_q && phase_end) begin
        if (state_q == LOW)  read_data[15:0]  <= sram_dq_in;
        if (state_q == HIGH) read_data[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    if (busy) begin
      sram_ce_n = 1'b0;
      sram_ub_n = 1'b0;
      sram_lb_n = 1'b0;
      sram_addr = {offset[18:2], (state_q == HIGH)};
      if (op_wr_q) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        sram_dq_out = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  // Combinational so a request arriving in IDLE stalls the pipeline that same cycle.
  assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

endmodule
